// File: rtl/md_if.sv
// md_if: operand/opcode request and HI/LO/busy response bundle for md_unit
interface md_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master(output start, op, a, b, input busy, hi, lo);
  modport slave(input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// md_unit: fixed-latency MULT/MULTU/DIV/DIVU and MTHI/MTLO with architectural HI/LO
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic clk,
  input logic reset,
  md_if.slave bus
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rhi_q, rhi_d, rlo_q, rlo_d, hi_q, hi_d, lo_q, lo_d;
  logic          wr_q, wr_d;
  logic          sgn;
  logic [63:0]   prod_s, prod_u;
  logic [31:0]   a_mag, b_mag, b_safe, quo, rem, quo_res, rem_res;

  // Result datapath: products, and sign-magnitude divide so the 0x80000000/-1 case falls out naturally
  always_comb begin
    sgn     = ~bus.op[0];
    prod_s  = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
    prod_u  = {32'b0, bus.a} * {32'b0, bus.b};
    a_mag   = (sgn && bus.a[31]) ? -bus.a : bus.a;
    b_mag   = (sgn && bus.b[31]) ? -bus.b : bus.b;
    b_safe  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    quo     = a_mag / b_safe;
    rem     = a_mag % b_safe;
    quo_res = (sgn && (bus.a[31] ^ bus.b[31])) ? -quo : quo;
    rem_res = (sgn && bus.a[31]) ? -rem : rem;
  end

  // Next state: accept in IDLE, count down in BUSY, commit the latched result on the last edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rhi_d   = rhi_q;
    rlo_d   = rlo_q;
    wr_d    = wr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q == BUSY) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q <= CW'(1)) begin
        state_d = IDLE;
        cnt_d   = '0;
        hi_d    = wr_q ? rhi_q : hi_q;
        lo_d    = wr_q ? rlo_q : lo_q;
      end
    end else if (bus.start && !bus.op[2]) begin
      state_d = BUSY;
      cnt_d   = bus.op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      rhi_d   = bus.op[1] ? rem_res : bus.op[0] ? prod_u[63:32] : prod_s[63:32];
      rlo_d   = bus.op[1] ? quo_res : bus.op[0] ? prod_u[31:0] : prod_s[31:0];
      wr_d    = !(bus.op[1] && bus.b == 32'd0);
    end else if (bus.start && bus.op[1:0] == 2'd0) begin
      hi_d = bus.a;
    end else if (bus.start && bus.op[1:0] == 2'd1) begin
      lo_d = bus.a;
    end
  end

  // State registers; reset drops any in-flight result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rhi_q   <= '0;
      rlo_q   <= '0;
      wr_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rhi_q   <= rhi_d;
      rlo_q   <= rlo_d;
      wr_q    <= wr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy = (state_q == BUSY);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed checks of md_unit arithmetic, latency, reset and busy behaviour
module tb_md_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc;

  md_if bus();
  md_unit dut(.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = 32'hDEAD_BEEF;
    bus.b = 32'h0BAD_F00D;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    #3;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %h exp 0", bus.busy); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL rst_hi got %h exp 0", bus.hi); end
    checks++; if (bus.lo !== 32'd0) begin errors++; $display("FAIL rst_lo got %h exp 0", bus.lo); end
    reset = 1'b0;
    @(posedge clk); #1;
    issue(3'd4, 32'h55, 32'd0);
    checks++; if (bus.hi !== 32'h55) begin errors++; $display("FAIL pre_mthi got %h exp 00000055", bus.hi); end
    issue(3'd0, 32'd3, 32'd4);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL async_busy got %h exp 0", bus.busy); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL async_hi got %h exp 0", bus.hi); end
    checks++; if (bus.lo !== 32'd0) begin errors++; $display("FAIL async_lo got %h exp 0", bus.lo); end
    #1 reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (bus.lo !== 32'd0) begin errors++; $display("FAIL post_rst_lo got %h exp 0", bus.lo); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy got %h exp 0", bus.busy); end
  endtask

  task automatic test_mult;
    issue(3'd0, 32'hFFFF_FFFF, 32'd2);
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL mult_stale_hi got %h exp 0", bus.hi); end
    wait_busy(cyc);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL mult_cycles got %0d exp 5", cyc); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h exp ffffffff", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mult_lo got %h exp fffffffe", bus.lo); end
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    wait_busy(cyc);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL multu_cycles got %0d exp 5", cyc); end
    checks++; if (bus.hi !== 32'd1) begin errors++; $display("FAIL multu_hi got %h exp 1", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_lo got %h exp fffffffe", bus.lo); end
  endtask

  task automatic test_div;
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_busy(cyc);
    checks++; if (cyc !== 10) begin errors++; $display("FAIL div_cycles got %0d exp 10", cyc); end
    checks++; if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h exp fffffffd", bus.lo); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h exp ffffffff", bus.hi); end
    issue(3'd2, 32'd7, 32'hFFFF_FFFE);
    wait_busy(cyc);
    checks++; if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_negb_lo got %h exp fffffffd", bus.lo); end
    checks++; if (bus.hi !== 32'd1) begin errors++; $display("FAIL div_negb_hi got %h exp 1", bus.hi); end
    issue(3'd3, 32'd7, 32'd2);
    wait_busy(cyc);
    checks++; if (bus.lo !== 32'd3) begin errors++; $display("FAIL divu_lo got %h exp 3", bus.lo); end
    checks++; if (bus.hi !== 32'd1) begin errors++; $display("FAIL divu_hi got %h exp 1", bus.hi); end
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_busy(cyc);
    checks++; if (bus.lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo got %h exp 80000000", bus.lo); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL div_ovf_hi got %h exp 0", bus.hi); end
  endtask

  task automatic test_div_zero;
    issue(3'd4, 32'h1234, 32'd0);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %h exp 0", bus.busy); end
    checks++; if (bus.hi !== 32'h1234) begin errors++; $display("FAIL mthi_hi got %h exp 1234", bus.hi); end
    issue(3'd5, 32'h5678, 32'd0);
    checks++; if (bus.lo !== 32'h5678) begin errors++; $display("FAIL mtlo_lo got %h exp 5678", bus.lo); end
    issue(3'd3, 32'd5, 32'd0);
    wait_busy(cyc);
    checks++; if (cyc !== 10) begin errors++; $display("FAIL dz_cycles got %0d exp 10", cyc); end
    checks++; if (bus.hi !== 32'h1234) begin errors++; $display("FAIL dz_hi got %h exp 1234", bus.hi); end
    checks++; if (bus.lo !== 32'h5678) begin errors++; $display("FAIL dz_lo got %h exp 5678", bus.lo); end
    issue(3'd6, 32'h9999, 32'd1);
    checks++; if (bus.busy !== 1'b0 || bus.hi !== 32'h1234 || bus.lo !== 32'h5678) begin errors++; $display("FAIL op6_noop got busy %h hi %h lo %h exp 0 1234 5678", bus.busy, bus.hi, bus.lo); end
  endtask

  task automatic test_busy_ignore;
    int n;
    issue(3'd2, 32'd100, 32'd7);
    n = 0;
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd2; bus.b = 32'd2;
    @(posedge clk); #1; n++;
    bus.start = 1'b0;
    @(posedge clk); #1; n++;
    bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'hAAAA;
    @(posedge clk); #1; n++;
    bus.start = 1'b0;
    checks++; if (bus.hi !== 32'h1234) begin errors++; $display("FAIL ign_mthi got %h exp 1234", bus.hi); end
    wait_busy(cyc);
    n += cyc;
    checks++; if (n !== 10) begin errors++; $display("FAIL ign_cycles got %0d exp 10", n); end
    checks++; if (bus.lo !== 32'd14) begin errors++; $display("FAIL ign_lo got %h exp e", bus.lo); end
    checks++; if (bus.hi !== 32'd2) begin errors++; $display("FAIL ign_hi got %h exp 2", bus.hi); end
  endtask

  task automatic test_back_to_back;
    issue(3'd1, 32'd3, 32'd3);
    wait_busy(cyc);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL b2b_cycles got %0d exp 5", cyc); end
    checks++; if (bus.lo !== 32'd9) begin errors++; $display("FAIL b2b_lo got %h exp 9", bus.lo); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL b2b_hi got %h exp 0", bus.hi); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op = 3'd0;
    bus.a = 32'd0;
    bus.b = 32'd0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_busy_ignore();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
